// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz raster timing constants, used by the tracker, the game FSM and the renderer.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    // Default horizontal geometry, in pixel clocks
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    // Default vertical geometry, in lines
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    // Derived values; *_END is exclusive (first coordinate after the sync pulse)
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef logic [COORD_W-1:0] coord_t;

    // One raster axis: visible span followed by front porch, sync and back porch
    typedef struct packed {
        coord_t active;
        coord_t fp;
        coord_t sync;
        coord_t bp;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } vga_timing_t;

    localparam vga_timing_t DEFAULT_TIMING = '{
        h: '{active: coord_t'(H_ACTIVE), fp: coord_t'(H_FP), sync: coord_t'(H_SYNC), bp: coord_t'(H_BP)},
        v: '{active: coord_t'(V_ACTIVE), fp: coord_t'(V_FP), sync: coord_t'(V_SYNC), bp: coord_t'(V_BP)}
    };

    // Number of positions on one axis (clocks per line or lines per frame)
    function automatic coord_t axis_total(axis_timing_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

endpackage

// File: rtl/vga_tracker_if.sv
// Raster output bundle from the timing generator to the renderer / game logic.
interface vga_tracker_if;
    import vga_timing_pkg::*;

    logic   h_sync;
    logic   v_sync;
    logic   video_on;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   frame_tik;
    logic   frame_start;

    modport master (
        output h_sync, v_sync, video_on, pixel_x, pixel_y, frame_tik, frame_start
    );

    modport slave (
        input h_sync, v_sync, video_on, pixel_x, pixel_y, frame_tik, frame_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis: counts 0..P_LAST while enabled,
// and flags the enabled clock on which it returns to 0.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter coord_t P_LAST = coord_t'(H_TOTAL - 1)
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_en,
    output coord_t o_cnt,
    output logic   o_wrap
);

    coord_t r_cnt;
    logic   w_tc;

    assign w_tc   = (r_cnt == P_LAST);
    assign o_wrap = i_en && w_tc;
    assign o_cnt  = r_cnt;

    // Position register: advance when enabled, wrap at the terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would race other flops.
            r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_tracker.sv
// Free-running raster timing generator. Two axis counters hold the current position;
// sync, blanking and frame markers are decoded from them and registered so that every
// output lags the counters by exactly one clock and all outputs stay mutually aligned.
module vga_tracker
    import vga_timing_pkg::*;
#(
    parameter vga_timing_t P_TIMING = DEFAULT_TIMING
) (
    input  logic          clock_25,
    input  logic          reset,
    vga_tracker_if.master vga
);

    localparam coord_t L_H_LAST   = axis_total(P_TIMING.h) - 1'b1;
    localparam coord_t L_V_LAST   = axis_total(P_TIMING.v) - 1'b1;
    localparam coord_t L_HS_START = P_TIMING.h.active + P_TIMING.h.fp;
    localparam coord_t L_HS_END   = L_HS_START + P_TIMING.h.sync;
    localparam coord_t L_VS_START = P_TIMING.v.active + P_TIMING.v.fp;
    localparam coord_t L_VS_END   = L_VS_START + P_TIMING.v.sync;
    localparam coord_t L_TIK_END  = P_TIMING.v.active + P_TIMING.v.fp;

    coord_t w_h_cnt;
    coord_t w_v_cnt;
    logic   w_h_wrap;
    logic   w_v_wrap;

    logic   w_hs_win;
    logic   w_vs_win;
    logic   w_visible;
    logic   w_tik_win;
    logic   w_origin;

    logic   r_h_sync;
    logic   r_v_sync;
    logic   r_video_on;
    coord_t r_pixel_x;
    coord_t r_pixel_y;
    logic   r_frame_tik;
    logic   r_frame_start;

    vga_axis_counter #(.P_LAST(L_H_LAST)) u_h_cnt (
        .clk    (clock_25),
        .rst_n  (reset),
        .i_en   (1'b1),
        .o_cnt  (w_h_cnt),
        .o_wrap (w_h_wrap)
    );

    // The line counter steps once per line; at (last, last) both wrap on the same edge
    vga_axis_counter #(.P_LAST(L_V_LAST)) u_v_cnt (
        .clk    (clock_25),
        .rst_n  (reset),
        .i_en   (w_h_wrap),
        .o_cnt  (w_v_cnt),
        .o_wrap (w_v_wrap)
    );

    // The frame only ever wraps from its very last pixel
    a_frame_wrap: assert property (@(posedge clock_25) disable iff (!reset)
        w_v_wrap |-> (w_h_cnt == L_H_LAST && w_v_cnt == L_V_LAST));

    assign w_hs_win  = (w_h_cnt >= L_HS_START) && (w_h_cnt < L_HS_END);
    assign w_vs_win  = (w_v_cnt >= L_VS_START) && (w_v_cnt < L_VS_END);
    assign w_visible = (w_h_cnt < P_TIMING.h.active) && (w_v_cnt < P_TIMING.v.active);
    assign w_tik_win = (w_v_cnt >= P_TIMING.v.active) && (w_v_cnt < L_TIK_END);
    assign w_origin  = (w_h_cnt == '0) && (w_v_cnt == '0);

    // Output flops: one-clock registered copy of the window decode and the counters
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            // NOTE: syncs idle high in reset so the monitor sees no spurious pulse while held.
            r_h_sync      <= 1'b1;
            r_v_sync      <= 1'b1;
            r_video_on    <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_frame_tik   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h_sync      <= !w_hs_win;
            r_v_sync      <= !w_vs_win;
            r_video_on    <= w_visible;
            r_pixel_x     <= w_h_cnt;
            r_pixel_y     <= w_v_cnt;
            r_frame_tik   <= w_tik_win;
            r_frame_start <= w_origin;
        end
    end

    assign vga.h_sync      = r_h_sync;
    assign vga.v_sync      = r_v_sync;
    assign vga.video_on    = r_video_on;
    assign vga.pixel_x     = r_pixel_x;
    assign vga.pixel_y     = r_pixel_y;
    assign vga.frame_tik   = r_frame_tik;
    assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_tracker.sv
// Bench for vga_tracker: a default-geometry instance (line-level timing) and a reduced
// geometry instance (frame-level timing) run side by side from one clock and reset.
module tb_vga_tracker;
    import vga_timing_pkg::*;

    // Reduced geometry: 16+2+3+3 = 24 clocks/line, 12+2+2+3 = 19 lines/frame
    localparam vga_timing_t SMALL = '{
        h: '{active: 10'd16, fp: 10'd2, sync: 10'd3, bp: 10'd3},
        v: '{active: 10'd12, fp: 10'd2, sync: 10'd2, bp: 10'd3}
    };

    logic clock_25 = 1'b0;
    logic reset    = 1'b0;

    always #20 clock_25 = ~clock_25;

    vga_tracker_if vd ();
    vga_tracker_if vs ();

    vga_tracker dut_def (
        .clock_25 (clock_25),
        .reset    (reset),
        .vga      (vd)
    );

    vga_tracker #(.P_TIMING(SMALL)) dut_small (
        .clock_25 (clock_25),
        .reset    (reset),
        .vga      (vs)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [24:0] q_def[$];
    logic [24:0] q_small[$];

    int mx_d, my_d, mx_s, my_s;
    int n_cyc;

    // line-level measurement state (default instance)
    bit prev_valid;
    bit prev_hs;
    int last_fall;
    int hs_low;
    // frame-level measurement state (small instance)
    bit prev_vs, prev_tik;
    int vs_low, tik_high, tik_rises, von_cnt, last_fs;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [24:0] model(int x, int y, int ha, int hfp, int hsw,
                                          int va, int vfp, int vsw);
        logic hsn, vsn, von, tik, fs;
        logic [9:0] xx, yy;
        hsn = !(x >= ha + hfp && x < ha + hfp + hsw);
        vsn = !(y >= va + vfp && y < va + vfp + vsw);
        von = (x < ha) && (y < va);
        tik = (y >= va) && (y < va + vfp);
        fs  = (x == 0) && (y == 0);
        xx  = 10'(x);
        yy  = 10'(y);
        return {hsn, vsn, von, tik, fs, xx, yy};
    endfunction

    function automatic logic [24:0] obs_def();
        return {vd.h_sync, vd.v_sync, vd.video_on, vd.frame_tik, vd.frame_start, vd.pixel_x, vd.pixel_y};
    endfunction

    function automatic logic [24:0] obs_small();
        return {vs.h_sync, vs.v_sync, vs.video_on, vs.frame_tik, vs.frame_start, vs.pixel_x, vs.pixel_y};
    endfunction

    function automatic logic [24:0] reset_pack();
        return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
    endfunction

    task automatic model_reset();
        mx_d = 0; my_d = 0; mx_s = 0; my_s = 0;
        q_def.delete();
        q_small.delete();
        prev_valid = 0;
        last_fall  = -1;
        hs_low     = 0;
        vs_low     = 0;
        tik_high   = 0;
        tik_rises  = 0;
        von_cnt    = 0;
        last_fs    = -1;
        n_cyc      = 0;
    endtask

    // Derived checks on top of the cycle-by-cycle scoreboard
    task automatic measure();
        if (vd.video_on)
            check("def_von_area", {31'd0, (vd.pixel_x < 10'd640) && (vd.pixel_y < 10'd480)}, 1);
        if (vs.video_on)
            check("sm_von_area", {31'd0, (vs.pixel_x < 10'd16) && (vs.pixel_y < 10'd12)}, 1);

        if (prev_valid) begin
            if (prev_hs && !vd.h_sync) begin
                check("hs_fall_x", vd.pixel_x, 656);
                if (last_fall >= 0) check("hs_period", n_cyc - last_fall, 800);
                last_fall = n_cyc;
                hs_low    = 0;
            end
            if (!prev_hs && vd.h_sync && last_fall >= 0) check("hs_low_width", hs_low, 96);

            if (prev_vs && !vs.v_sync) begin
                check("vs_fall_xy", {vs.pixel_x, vs.pixel_y}, {10'd0, 10'd14});
                vs_low = 0;
            end
            if (!prev_vs && vs.v_sync && last_fs >= 0) check("vs_low_width", vs_low, 48);

            if (!prev_tik && vs.frame_tik) begin
                check("tik_rise_xy", {vs.pixel_x, vs.pixel_y}, {10'd0, 10'd12});
                tik_rises++;
                tik_high = 0;
            end
            if (prev_tik && !vs.frame_tik) begin
                check("tik_fall_xy", {vs.pixel_x, vs.pixel_y}, {10'd0, 10'd14});
                check("tik_width", tik_high, 48);
            end
        end

        if (vs.frame_start) begin
            if (last_fs >= 0) begin
                check("fs_period", n_cyc - last_fs, 456);
                check("von_per_frame", von_cnt, 192);
                check("tik_rises_per_frame", tik_rises, 1);
            end
            last_fs   = n_cyc;
            von_cnt   = 0;
            tik_rises = 0;
        end

        if (!vd.h_sync)    hs_low++;
        if (!vs.v_sync)    vs_low++;
        if (vs.frame_tik)  tik_high++;
        if (vs.video_on)   von_cnt++;
        prev_hs    = vd.h_sync;
        prev_vs    = vs.v_sync;
        prev_tik   = vs.frame_tik;
        prev_valid = 1;
    endtask

    // One clock: push expected outputs at the edge, compare them half a period later
    task automatic tick();
        @(posedge clock_25);
        if (reset) begin
            q_def.push_back(model(mx_d, my_d, 640, 16, 96, 480, 10, 2));
            q_small.push_back(model(mx_s, my_s, 16, 2, 3, 12, 2, 2));
            mx_d++;
            if (mx_d == 800) begin mx_d = 0; my_d++; if (my_d == 525) my_d = 0; end
            mx_s++;
            if (mx_s == 24) begin mx_s = 0; my_s++; if (my_s == 19) my_s = 0; end
        end
        @(negedge clock_25);
        if (q_def.size() > 0)   check("def_out", obs_def(), q_def.pop_front());
        if (q_small.size() > 0) check("sm_out", obs_small(), q_small.pop_front());
        if (reset) begin
            n_cyc++;
            measure();
        end
    endtask

    initial begin
        bit found;
        int cnt;

        model_reset();
        repeat (3) tick();
        check("rst_def", obs_def(), reset_pack());
        check("rst_small", obs_small(), reset_pack());

        reset = 1'b1;
        tick();
        check("first_def_xy", {vd.pixel_x, vd.pixel_y}, 0);
        check("first_def_flags", {vd.video_on, vd.frame_start, vd.h_sync, vd.v_sync}, 4'b1111);
        check("first_small_flags", {vs.video_on, vs.frame_start, vs.h_sync, vs.v_sync}, 4'b1111);

        repeat (3000) tick();

        // Walk to pixel_x = 300 and pull reset in the middle of the line
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick();
            if (vd.pixel_x == 10'd300) found = 1;
        end
        check("reach_x300", {31'd0, found}, 1);

        #5 reset = 1'b0;
        #1;
        check("async_rst_def", obs_def(), reset_pack());
        check("async_rst_small", obs_small(), reset_pack());
        model_reset();
        repeat (2) tick();
        check("held_rst_def", obs_def(), reset_pack());

        reset = 1'b1;
        tick();
        check("restart_def_flags", {vd.video_on, vd.frame_start, vd.pixel_x, vd.pixel_y}, {2'b11, 20'd0});

        // First line after release must still be a full 800 clocks
        found = 0;
        cnt   = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick();
            cnt++;
            if (vd.pixel_x == 10'd0 && vd.pixel_y == 10'd1) found = 1;
        end
        check("restart_line_len", found ? cnt : -1, 800);

        repeat (1200) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
